instr_exec_register: RTL
========================

# instr_exec_register

Parametrised next-generation instruction register with an integrated execute stage. Each accepted instruction (opcode, two signed operands) is written into a DEPTH-entry register file together with its computed result. Single-cycle ops complete at the load edge. DIV/MOD run on an iterative divider behind a ready handshake. It sits between the instruction stimulus source and the checker/read-back logic, replacing the fixed 32-bit, compute-free register.

## Interface
- OP_WIDTH, 32: operand width in bits, signed; result width is 2*OP_WIDTH.
- DEPTH, 32: number of register-file entries; AW = $clog2(DEPTH).
- clk  in  1  single clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- load_en  in  1  load request; accepted only when load_ready=1.
- load_ready  out  1  block can accept a load this cycle.
- opcode  in  4  opcode_t: ZERO=0, PASSA=1, PASSB=2, ADD=3, SUB=4, MULT=5, DIV=6, MOD=7; values 8–15 are illegal.
- operand_a, operand_b  in  OP_WIDTH  signed operands.
- write_pointer  in  AW  destination entry.
- read_pointer  in  AW  read-back entry.
- rd_opc  out  4; rd_op_a / rd_op_b  out  OP_WIDTH; rd_result  out  2*OP_WIDTH: combinational read of the entry at read_pointer.
- rd_valid  out  1  the entry at read_pointer holds a completed result.
- rd_error  out  1  the entry at read_pointer completed with divide-by-zero or an illegal opcode.
- wb_valid  out  1  one-cycle pulse at result writeback; wb_pointer  out  AW  the entry written.

## Operation
- Accept condition is load_en & load_ready at a rising edge. The opcode, operands, and a cleared valid bit are captured into entry[write_pointer].
- Arithmetic is signed. Operands are sign-extended to 2*OP_WIDTH before computing, so no op overflows.
- ZERO gives 0. PASSA gives sext(a). PASSB gives sext(b). ADD gives a+b. SUB gives a-b. MULT gives the full 2*OP_WIDTH product.
- DIV truncates toward zero. MOD takes the sign of the dividend, matching SV / and %. (-2^(W-1)) / -1 yields +2^(W-1), which is representable.
- Divide by zero (DIV or MOD with b=0): result 0, error=1.
- Illegal opcode: result 0, error=1, single-cycle path.
- Divider FSM states:
  - IDLE: load_ready=1.
  - DIVIDE: restoring divider on operand magnitudes, one quotient bit per cycle, OP_WIDTH cycles.
  - WRITEBACK: sign fix-up, write result/error, set valid. Then return to IDLE.
- Divide by zero skips DIVIDE: IDLE → WRITEBACK.
- A pointer ≥ DEPTH (non-power-of-two DEPTH) on write: the load is accepted but has no effect, and wb_valid does not pulse. On read: all rd_* outputs are 0.
- Rewriting an entry overwrites it completely. Reads of the entry being computed show rd_valid=0.

## Timing
- Reset (asynchronous assert, synchronous-safe release) sets:
  - every entry: opc=0, operands=0, result=0, valid=0, error=0;
  - FSM=IDLE, load_ready=1, wb_valid=0, wb_pointer=0.
- Single-cycle op accepted at edge k: the entry is complete at edge k, with rd_valid=1 from then on. wb_valid pulses during cycle k→k+1. load_ready stays 1, so back-to-back loads are allowed every cycle.
- DIV/MOD accepted at edge k:
  - load_ready falls after edge k.
  - DIVIDE runs over edges k+1 to k+OP_WIDTH.
  - WRITEBACK at edge k+OP_WIDTH+1: result written, wb_valid pulses, load_ready returns to 1. Total latency is OP_WIDTH+1 cycles.
- Divide by zero: writeback at edge k+1, 1 busy cycle.
- load_en while load_ready=0 is ignored: nothing is queued and no entry changes.
- Reset mid-division aborts the operation. The target entry is cleared like all others, and no wb_valid pulse occurs.
- Read port is purely combinational. The value updates in the same cycle as a read_pointer change and after the write edge.

## Test plan
- Reset with dirty state:
  - Stimulus: load several entries, then assert reset_n=0 mid-cycle.
  - Response: all rd_* = 0 immediately. load_ready=1. wb_valid=0.
- ADD/MULT, OP_WIDTH=32:
  - Stimulus: ADD 7,-12 at edge k.
  - Response: rd_result=-5, rd_valid=1 at k, wb_valid pulses once.
  - Stimulus: MULT -2^31 × -2^31.
  - Response: result=2^62.
- DIV latency:
  - Stimulus: DIV -7,2.
  - Response: load_ready=0 for 33 cycles, then result=-3, rd_valid=1, exactly one wb_valid at edge k+33.
  - Stimulus: MOD -7,2.
  - Response: result=-1.
- Corner and error cases:
  - Stimulus: DIV -2^31,-1.
  - Response: result=+2^31.
  - Stimulus: DIV 5,0.
  - Response: result=0, rd_error=1, done at k+1.
  - Stimulus: opcode 12.
  - Response: result=0, rd_error=1, single cycle.
- Load while busy:
  - Stimulus: load_en=1 with ADD to entry 3 during a DIVIDE.
  - Response: entry 3 unchanged. The ADD applies only after load_ready returns to 1.
- Reset mid-DIV and overwrite:
  - Stimulus: assert reset at cycle 10 of a DIVIDE.
  - Response: no wb_valid, entry cleared, IDLE.
  - Stimulus: rewrite entry 0 with PASSB 9 after a prior DIV to entry 0.
  - Response: rd_result=9.

Source files
------------

// File: rtl/instr_exec_register.sv
// rtl/instr_exec_register.sv - instruction register file with integrated execute stage and iterative divider
module instr_exec_register #(
    parameter  int OP_WIDTH = 32,
    parameter  int DEPTH    = 32,
    localparam int AW       = $clog2(DEPTH),
    localparam int RW       = 2 * OP_WIDTH
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       load_en,
    output logic                       load_ready,
    input  logic [3:0]                 opcode,
    input  logic signed [OP_WIDTH-1:0] operand_a,
    input  logic signed [OP_WIDTH-1:0] operand_b,
    input  logic [AW-1:0]              write_pointer,
    input  logic [AW-1:0]              read_pointer,
    output logic [3:0]                 rd_opc,
    output logic [OP_WIDTH-1:0]        rd_op_a,
    output logic [OP_WIDTH-1:0]        rd_op_b,
    output logic [RW-1:0]              rd_result,
    output logic                       rd_valid,
    output logic                       rd_error,
    output logic                       wb_valid,
    output logic [AW-1:0]              wb_pointer
);

    localparam logic [3:0] OP_ZERO  = 4'd0;
    localparam logic [3:0] OP_PASSA = 4'd1;
    localparam logic [3:0] OP_PASSB = 4'd2;
    localparam logic [3:0] OP_ADD   = 4'd3;
    localparam logic [3:0] OP_SUB   = 4'd4;
    localparam logic [3:0] OP_MULT  = 4'd5;
    localparam logic [3:0] OP_DIV   = 4'd6;
    localparam logic [3:0] OP_MOD   = 4'd7;

    localparam int            CW      = $clog2(OP_WIDTH);
    localparam logic [CW-1:0] LAST    = CW'(OP_WIDTH - 1);
    localparam logic [AW:0]   DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_DIVIDE, S_WRITEBACK} state_t;

    state_t state_q, state_d;

    logic [3:0]          opc_q   [DEPTH];
    logic [OP_WIDTH-1:0] a_q     [DEPTH];
    logic [OP_WIDTH-1:0] b_q     [DEPTH];
    logic [RW-1:0]       res_q   [DEPTH];
    logic                valid_q [DEPTH];
    logic                err_q   [DEPTH];

    logic [OP_WIDTH-1:0] dq_q, rem_q, dvs_q;
    logic [CW-1:0]       cnt_q;
    logic [AW-1:0]       ptr_q;
    logic                neg_q_q, neg_r_q, is_mod_q, dz_q;

    logic                accept, wr_in_range, rd_in_range, is_divmod, b_zero, start_div;
    logic signed [RW-1:0] a_ext, b_ext;
    logic [RW-1:0]       sc_result;
    logic                sc_error;
    logic [OP_WIDTH-1:0] a_u, b_u, mag_a, mag_b;
    logic [OP_WIDTH:0]   rem_shift, diff;
    logic                ge;
    logic [RW-1:0]       q_ext, r_ext, div_result;

    assign load_ready  = (state_q == S_IDLE);
    assign accept      = load_en && load_ready;
    assign wr_in_range = {1'b0, write_pointer} < DEPTH_L;
    assign rd_in_range = {1'b0, read_pointer} < DEPTH_L;
    assign is_divmod   = (opcode == OP_DIV) || (opcode == OP_MOD);
    assign b_zero      = (operand_b == '0);
    assign start_div   = accept && wr_in_range && is_divmod;

    assign a_ext = {{OP_WIDTH{operand_a[OP_WIDTH-1]}}, operand_a};
    assign b_ext = {{OP_WIDTH{operand_b[OP_WIDTH-1]}}, operand_b};

    // Illegal opcodes land in the default arm; DIV/MOD never use this path.
    always_comb begin
        sc_result = '0;
        sc_error  = 1'b0;
        case (opcode)
            OP_ZERO:  sc_result = '0;
            OP_PASSA: sc_result = a_ext;
            OP_PASSB: sc_result = b_ext;
            OP_ADD:   sc_result = a_ext + b_ext;
            OP_SUB:   sc_result = a_ext - b_ext;
            OP_MULT:  sc_result = a_ext * b_ext;
            default:  sc_error  = 1'b1;
        endcase
    end

    // Magnitudes fit unsigned OP_WIDTH bits, including the most negative operand.
    assign a_u   = operand_a;
    assign b_u   = operand_b;
    assign mag_a = a_u[OP_WIDTH-1] ? -a_u : a_u;
    assign mag_b = b_u[OP_WIDTH-1] ? -b_u : b_u;

    assign rem_shift = {rem_q, dq_q[OP_WIDTH-1]};
    assign diff      = rem_shift - {1'b0, dvs_q};
    assign ge        = ~diff[OP_WIDTH];

    assign q_ext = {{OP_WIDTH{1'b0}}, dq_q};
    assign r_ext = {{OP_WIDTH{1'b0}}, rem_q};

    always_comb begin
        div_result = '0;
        if (!dz_q) begin
            if (is_mod_q) div_result = neg_r_q ? -r_ext : r_ext;
            else          div_result = neg_q_q ? -q_ext : q_ext;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:      if (start_div) state_d = b_zero ? S_WRITEBACK : S_DIVIDE;
            S_DIVIDE:    if (cnt_q == LAST) state_d = S_WRITEBACK;
            S_WRITEBACK: state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= S_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dq_q     <= '0;
            rem_q    <= '0;
            dvs_q    <= '0;
            cnt_q    <= '0;
            ptr_q    <= '0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            is_mod_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (state_q == S_IDLE && start_div) begin
            dq_q     <= mag_a;
            rem_q    <= '0;
            dvs_q    <= mag_b;
            cnt_q    <= '0;
            ptr_q    <= write_pointer;
            neg_q_q  <= operand_a[OP_WIDTH-1] ^ operand_b[OP_WIDTH-1];
            neg_r_q  <= operand_a[OP_WIDTH-1];
            is_mod_q <= (opcode == OP_MOD);
            dz_q     <= b_zero;
        end else if (state_q == S_DIVIDE) begin
            rem_q <= ge ? diff[OP_WIDTH-1:0] : rem_shift[OP_WIDTH-1:0];
            dq_q  <= {dq_q[OP_WIDTH-2:0], ge};
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Loads and divider writebacks never coincide: loads are only accepted in IDLE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                opc_q[i]   <= '0;
                a_q[i]     <= '0;
                b_q[i]     <= '0;
                res_q[i]   <= '0;
                valid_q[i] <= 1'b0;
                err_q[i]   <= 1'b0;
            end
            wb_valid   <= 1'b0;
            wb_pointer <= '0;
        end else begin
            wb_valid <= 1'b0;
            if (accept && wr_in_range) begin
                opc_q[write_pointer] <= opcode;
                a_q[write_pointer]   <= operand_a;
                b_q[write_pointer]   <= operand_b;
                if (is_divmod) begin
                    res_q[write_pointer]   <= '0;
                    valid_q[write_pointer] <= 1'b0;
                    err_q[write_pointer]   <= 1'b0;
                end else begin
                    res_q[write_pointer]   <= sc_result;
                    valid_q[write_pointer] <= 1'b1;
                    err_q[write_pointer]   <= sc_error;
                    wb_valid               <= 1'b1;
                    wb_pointer             <= write_pointer;
                end
            end
            if (state_q == S_WRITEBACK) begin
                res_q[ptr_q]   <= div_result;
                valid_q[ptr_q] <= 1'b1;
                err_q[ptr_q]   <= dz_q;
                wb_valid       <= 1'b1;
                wb_pointer     <= ptr_q;
            end
        end
    end

    always_comb begin
        rd_opc    = '0;
        rd_op_a   = '0;
        rd_op_b   = '0;
        rd_result = '0;
        rd_valid  = 1'b0;
        rd_error  = 1'b0;
        if (rd_in_range) begin
            rd_opc    = opc_q[read_pointer];
            rd_op_a   = a_q[read_pointer];
            rd_op_b   = b_q[read_pointer];
            rd_result = res_q[read_pointer];
            rd_valid  = valid_q[read_pointer];
            rd_error  = err_q[read_pointer];
        end
    end

endmodule
